// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the forwarding scoreboard.
//   fwd_entry_t : one in-flight instruction slot {valid, rd, we, is_load}
//   rd_t        : register index storage; wide enough for any REGW <= RD_MAXW
//   SEL_RF      : select code meaning "take the register-file value"
//   sel_imm()   : select code meaning "take the immediate" for a given DEPTH
package fwd_pkg;

  localparam int DEPTH_DEF = 2;
  localparam int REGW_DEF  = 5;
  localparam int RD_MAXW   = 8;
  localparam int SEL_RF    = 0;

  typedef logic [RD_MAXW-1:0] rd_t;

  typedef struct packed {
    logic valid;
    rd_t  rd;
    logic we;
    logic is_load;
  } fwd_entry_t;

  // Immediate code sits one above the deepest forwarding stage.
  function automatic int sel_imm(input int depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority search of N scoreboard entries for one register index.
//   ent    : entries, index 0 is the youngest (nearest) producer
//   key    : register index to look for
//   use_en : the lookup is wanted at all
//   code   : 0 when nothing matches, else (index of nearest match) + 1
// Index 0 is never a hit, so x0 is never forwarded.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int N    = 2,
  parameter int SELW = 2
) (
  input  fwd_entry_t [N-1:0] ent,
  input  rd_t                key,
  input  logic               use_en,
  output logic [SELW-1:0]    code
);

  logic unused_load;

  always_comb begin
    code        = '0;
    unused_load = 1'b0;
    // Walk oldest to youngest so the youngest hit is assigned last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      unused_load = unused_load ^ ent[i].is_load;
      if (use_en && (key != '0) && ent[i].valid && ent[i].we && (ent[i].rd == key))
        code = SELW'(i + 1);
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// forward_scoreboard: forwarding and hazard unit beside the Decode/Execute
// pipeline register.
//   clk, rst            : clock, synchronous active-high reset
//   d_*                 : the instruction currently in Decode
//   e_flush             : Execute redirect, kills Decode and Execute contents
//   m_mem_ready         : memory op in stage 1 has finished its access
//   stall               : hold PC and Decode (combinational)
//   rs1_sel/rs2_sel     : Execute operand mux selects (0 = regfile, k = stage k,
//                         DEPTH+1 on rs2 = immediate)
//   rs2_sw_sel          : store-data select (0 = regfile, k = stage k)
//   stall_cnt           : saturating count of stalled cycles
// Scoreboard slot 0 is Execute, slot k is post-execute stage k.
module forward_scoreboard
  import fwd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int REGW  = REGW_DEF,
  parameter int SELW  = $clog2(DEPTH + 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            d_valid,
  input  logic [REGW-1:0] d_rs1,
  input  logic [REGW-1:0] d_rs2,
  input  logic            d_use_rs1,
  input  logic            d_use_rs2,
  input  logic [REGW-1:0] d_rd,
  input  logic            d_we,
  input  logic            d_is_load,
  input  logic            d_alu_src,
  input  logic            e_flush,
  input  logic            m_mem_ready,
  output logic            stall,
  output logic [SELW-1:0] rs1_sel,
  output logic [SELW-1:0] rs2_sel,
  output logic [SELW-1:0] rs2_sw_sel,
  output logic [15:0]     stall_cnt
);

  localparam logic [SELW-1:0] SEL_RF_C  = SELW'(SEL_RF);
  localparam logic [SELW-1:0] SEL_IMM_C = SELW'(sel_imm(DEPTH));

  fwd_entry_t [DEPTH:0]   sb;
  fwd_entry_t [DEPTH-1:0] srch;
  fwd_entry_t [1:0]       src_ent;
  fwd_entry_t             d_ent;
  fwd_entry_t             ent0_next;
  logic [SELW-1:0]        code1;
  logic [SELW-1:0]        code2;
  logic [1:0]             lu_code;
  logic                   load_use;
  logic                   freeze;
  logic                   issue;
  logic                   advance;
  logic                   unused_tail;

  // Slots 0..DEPTH-1 become stages 1..DEPTH after the advancing edge, which
  // is why a hit at slot i is encoded as i+1.
  assign srch        = sb[DEPTH-1:0];
  assign unused_tail = ^sb[DEPTH];

  assign d_ent = '{valid:   1'b1,
                   rd:      rd_t'(d_rd),
                   we:      d_we & (d_rd != '0),
                   is_load: d_is_load};

  fwd_match #(.N(DEPTH), .SELW(SELW)) u_match_rs1 (
    .ent    (srch),
    .key    (rd_t'(d_rs1)),
    .use_en (d_use_rs1),
    .code   (code1)
  );

  fwd_match #(.N(DEPTH), .SELW(SELW)) u_match_rs2 (
    .ent    (srch),
    .key    (rd_t'(d_rs2)),
    .use_en (d_use_rs2),
    .code   (code2)
  );

  // Load-use reuses the matcher with roles swapped: the key is the load's
  // destination and the "entries" are the two Decode sources.
  assign src_ent[0] = '{valid: d_use_rs1, rd: rd_t'(d_rs1), we: 1'b1, is_load: 1'b0};
  assign src_ent[1] = '{valid: d_use_rs2, rd: rd_t'(d_rs2), we: 1'b1, is_load: 1'b0};

  fwd_match #(.N(2), .SELW(2)) u_match_lu (
    .ent    (src_ent),
    .key    (sb[0].rd),
    .use_en (d_valid & sb[0].valid & sb[0].is_load & sb[0].we),
    .code   (lu_code)
  );

  assign load_use = (lu_code != 2'b00);
  // Stores carry is_load=0 and so never hold the pipe here.
  assign freeze   = sb[1].valid & sb[1].is_load & ~m_mem_ready;
  assign stall    = ~e_flush & (load_use | freeze);
  assign issue    = d_valid & ~load_use & ~e_flush;
  // A flush still drains the older stages even while frozen.
  assign advance  = e_flush | ~freeze;

  always_comb begin
    ent0_next = '0;
    if (issue)
      ent0_next = d_ent;
  end

  // Decode -> Execute boundary: scoreboard shift and registered selects
  always_ff @(posedge clk) begin
    if (rst) begin
      sb         <= '0;
      rs1_sel    <= SEL_RF_C;
      rs2_sel    <= SEL_RF_C;
      rs2_sw_sel <= SEL_RF_C;
    end else if (advance) begin
      sb      <= {sb[DEPTH-1:0], ent0_next};
      rs1_sel <= issue ? code1 : SEL_RF_C;
      if (issue && d_alu_src) begin
        rs2_sel    <= SEL_IMM_C;
        rs2_sw_sel <= code2;
      end else if (issue) begin
        rs2_sel    <= code2;
        rs2_sw_sel <= SEL_RF_C;
      end else begin
        rs2_sel    <= SEL_RF_C;
        rs2_sw_sel <= SEL_RF_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule
